// File: rtl/uart_receiver.sv
// 8N1 UART receiver with sticky frame/overrun flags and a ready/valid byte output.
// Define UART_RECEIVER_FIFO_EN for 4-entry FIFO storage; default is a single holding register.
module uart_receiver #(
   parameter int clk_freq_hz = 50000000,
   parameter int baud_rate   = 1000000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   input  logic       i_clear
);

   localparam int DIV = clk_freq_hz / baud_rate;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(DIV - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic          rx_m, rx_s, rx_d;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          push, frame_set, overrun_set, pop;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= i_uart_rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Only a fresh falling edge starts a frame, so a line stuck low is ignored.
               if (rx_d && !rx_s) begin
                  state <= START;
                  cnt   <= HALF;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (!rx_s) begin
                     state <= DATA;
                     cnt   <= FULL;
                     idx   <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shreg[idx] <= rx_s;
                  idx        <= idx + 1'b1;
                  cnt        <= FULL;
                  if (idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STOP: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      push      = (state == STOP) && (cnt == '0) && rx_s;
      frame_set = (state == STOP) && (cnt == '0) && !rx_s;
   end

`ifdef UART_RECEIVER_FIFO_EN
   logic [7:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       accept;

   always_comb begin
      pop         = (count != 3'd0) && i_ready;
      accept      = push && ((count != 3'd4) || pop);
      overrun_set = push && !accept;
      o_valid     = (count != 3'd0);
      o_data      = mem[rd_ptr];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
`else
   logic [7:0] hold;
   logic       hold_valid;

   always_comb begin
      pop         = hold_valid && i_ready;
      overrun_set = push && hold_valid && !pop;
      o_valid     = hold_valid;
      o_data      = hold;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold       <= '0;
         hold_valid <= 1'b0;
      end else if (push && (!hold_valid || pop)) begin
         hold       <= shreg;
         hold_valid <= 1'b1;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   // Set beats clear when both land in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= frame_set   | (o_frame_err & ~i_clear);
         o_overrun   <= overrun_set | (o_overrun   & ~i_clear);
      end
   end

endmodule
